// File: rtl/wb_pkg.sv
// wb_pkg: shared state encoding, default widths and a counter
// width helper for the Wishbone master bridge.
package wb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    BUS     = 3'b010,
    BACKOFF = 3'b100
  } wb_state_e;

  localparam int WB_DW = 32;
  localparam int WB_AW = 32;

  // Bits needed to hold 0..n, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// wb_timeout_cnt: loadable down-counter that parks at zero and
// flags expiry; used for both the bus timeout and the retry gap.
module wb_timeout_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  // Load wins over decrement; the count holds once it hits zero.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/wb_master_bridge.sv
// wb_master_bridge: single-outstanding Wishbone B4 classic master
// with retry, bus timeout and kill, all outputs registered.
module wb_master_bridge
  import wb_pkg::*;
#(
  parameter  int DW        = WB_DW,
  parameter  int AW        = WB_AW,
  localparam int SW        = DW / 8,
  parameter  int TIMEOUT   = 255,
  parameter  int MAX_RETRY = 3,
  parameter  int RETRY_GAP = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] wbm_dat_i,
  input  logic [AW-1:0] wbm_addr_i,
  input  logic [SW-1:0] wbm_sel_i,
  input  logic          wbm_we_i,
  input  logic          wbm_re_i,
  input  logic          wbm_kill_i,
  output logic          wbm_busy_o,
  output logic          wbm_ack_o,
  output logic [DW-1:0] wbm_dat_o,
  output logic          wbm_err_o,
  input  logic [DW-1:0] wbs_dat_i,
  input  logic          wbs_ack_i,
  input  logic          wbs_err_i,
  input  logic          wbs_rty_i,
  output logic          wbs_cyc_o,
  output logic          wbs_stb_o,
  output logic [DW-1:0] wbs_dat_o,
  output logic [AW-1:0] wbs_addr_o,
  output logic          wbs_we_o,
  output logic [SW-1:0] wbs_sel_o
);

  localparam int TW = cnt_w(TIMEOUT);
  localparam int RW = cnt_w(MAX_RETRY);
  localparam int GW = cnt_w(RETRY_GAP);

  localparam logic [TW-1:0] TO_LOAD =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [GW-1:0] GAP_LOAD =
    GW'((RETRY_GAP > 1) ? RETRY_GAP - 1 : 0);
  localparam logic [RW-1:0] RTY_MAX = RW'(MAX_RETRY);

  wb_state_e     state_q, state_d;
  logic          bus_q, bus_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic [DW-1:0] rdat_q, rdat_d;
  logic [DW-1:0] wdat_q, wdat_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          we_q, we_d;
  logic [RW-1:0] retry_q, retry_d;

  logic to_load, to_en, to_exp, to_hit;
  logic gap_load, gap_en, gap_exp;
  logic cnt_clr;

  assign to_hit = (TIMEOUT != 0) && to_exp;

  wb_timeout_cnt #(.W(TW)) u_to_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (cnt_clr),
    .load_i     (to_load),
    .en_i       (to_en),
    .load_val_i (TO_LOAD),
    .expired_o  (to_exp)
  );

  wb_timeout_cnt #(.W(GW)) u_gap_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (cnt_clr),
    .load_i     (gap_load),
    .en_i       (gap_en),
    .load_val_i (GAP_LOAD),
    .expired_o  (gap_exp)
  );

  // Next state and next registered outputs; kill > err > ack > rty > timeout.
  always_comb begin
    state_d  = state_q;
    bus_d    = bus_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rdat_d   = rdat_q;
    wdat_d   = wdat_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    we_d     = we_q;
    retry_d  = retry_q;
    to_load  = 1'b0;
    to_en    = 1'b0;
    gap_load = 1'b0;
    gap_en   = 1'b0;
    cnt_clr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((wbm_we_i ^ wbm_re_i) && !wbm_kill_i) begin
          state_d = BUS;
          bus_d   = 1'b1;
          wdat_d  = wbm_dat_i;
          addr_d  = wbm_addr_i;
          sel_d   = wbm_sel_i;
          we_d    = wbm_we_i;
          to_load = 1'b1;
        end
      end
      BUS: begin
        to_en = 1'b1;
        if (wbm_kill_i) begin
          state_d = IDLE;
          bus_d   = 1'b0;
        end else if (wbs_err_i) begin
          state_d = IDLE;
          bus_d   = 1'b0;
          ack_d   = 1'b1;
          err_d   = 1'b1;
        end else if (wbs_ack_i) begin
          state_d = IDLE;
          bus_d   = 1'b0;
          ack_d   = 1'b1;
          rdat_d  = wbs_dat_i;
        end else if (wbs_rty_i) begin
          bus_d = 1'b0;
          if (retry_q < RTY_MAX) begin
            state_d  = BACKOFF;
            retry_d  = retry_q + 1'b1;
            gap_load = 1'b1;
          end else begin
            state_d = IDLE;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end
        end else if (to_hit) begin
          state_d = IDLE;
          bus_d   = 1'b0;
          ack_d   = 1'b1;
          err_d   = 1'b1;
        end
      end
      BACKOFF: begin
        if (wbm_kill_i) begin
          state_d = IDLE;
        end else if (gap_exp) begin
          state_d = BUS;
          bus_d   = 1'b1;
          to_load = 1'b1;
        end else begin
          gap_en = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        bus_d   = 1'b0;
      end
    endcase
    if (state_d == IDLE) begin
      retry_d = '0;
      cnt_clr = 1'b1;
    end
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      bus_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdat_q  <= '0;
      wdat_q  <= '0;
      addr_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      bus_q   <= bus_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rdat_q  <= rdat_d;
      wdat_q  <= wdat_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      retry_q <= retry_d;
    end
  end

  assign wbm_busy_o = busy_q;
  assign wbm_ack_o  = ack_q;
  assign wbm_err_o  = err_q;
  assign wbm_dat_o  = rdat_q;
  assign wbs_cyc_o  = bus_q;
  assign wbs_stb_o  = bus_q;
  assign wbs_dat_o  = wdat_q;
  assign wbs_addr_o = addr_q;
  assign wbs_we_o   = we_q;
  assign wbs_sel_o  = sel_q;

endmodule
